// File: rtl/mult_share_arb.sv
// ============================================================================
// Module   : mult_share_arb
// Brief    : Round-robin arbiter/sequencer sharing one sequential multiplier
//            among NREQ requesters. Optional watchdog: MULT_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_flat,
    input  logic [NREQ*WIDTH-1:0]   b_flat,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      product,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_ready,
    input  logic [2*WIDTH-1:0]      mul_product
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    output logic                    err
`endif
);

    localparam int IDXW = $clog2(NREQ);
    localparam int SW   = IDXW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESULT    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IDXW-1:0]     r_idx;
    logic [IDXW-1:0]     r_rr_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [2*WIDTH-1:0]  r_product;
    logic                r_mul_start;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;

    logic [NREQ-1:0]     w_gnt_nxt;
    logic [NREQ-1:0]     w_done_nxt;
    logic                w_start_nxt;
    logic                w_load;
    logic                w_capture;
    logic                w_timeout;

    logic                w_found;
    logic [IDXW-1:0]     w_win;
    logic [SW-1:0]       w_sum;

    // Search upward from rr_ptr+1 with wrap; the last slot visited is rr_ptr itself.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(off);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            if (!w_found && req[w_sum[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDXW-1:0];
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] r_cnt;
    logic            r_err;

    assign w_timeout = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
                       (r_cnt == CNTW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_start_nxt = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && mul_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_start_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!mul_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (mul_ready) begin
                    w_state_nxt = S_RESULT;
                    w_capture   = 1'b1;
                    w_done_nxt  = NREQ'(1) << r_idx;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESULT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rr_ptr    <= IDXW'(NREQ - 1);
            r_gnt       <= '0;
            r_done      <= '0;
            r_product   <= '0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_mul_start <= w_start_nxt;
            if (w_load) begin
                r_mul_a  <= a_flat[w_win*WIDTH +: WIDTH];
                r_mul_b  <= b_flat[w_win*WIDTH +: WIDTH];
                r_idx    <= w_win;
                r_rr_ptr <= w_win;
            end
            if (w_capture) begin
                r_product <= mul_product;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Counter restarts whenever the state changes, so each wait state gets its own budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout && (w_state_nxt == S_IDLE);
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign err = r_err;
`endif

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign product   = r_product;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
// ============================================================================
// Module   : tb_mult_share_arb
// Brief    : Scoreboard bench for mult_share_arb with a behavioural multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int M     = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  a_flat;
    logic [NREQ*WIDTH-1:0]  b_flat;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [2*WIDTH-1:0]     product;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_ready;
    logic [2*WIDTH-1:0]     mul_product;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(64)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .a_flat      (a_flat),
        .b_flat      (b_flat),
        .gnt         (gnt),
        .done        (done),
        .product     (product),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product)
    );

    // Behavioural multiplier: busy for M cycles after a start, same reset.
    int                 stub_cnt;
    logic [2*WIDTH-1:0] stub_prod;
    logic               hold_low;

    always @(posedge clk) begin
        if (reset) begin
            stub_cnt  <= 0;
            stub_prod <= '0;
        end else if (mul_start && stub_cnt == 0) begin
            stub_cnt  <= M;
            stub_prod <= mul_a * mul_b;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign mul_ready   = (stub_cnt == 0) && !hold_low;
    assign mul_product = stub_prod;

    typedef struct {
        int                 idx;
        logic [2*WIDTH-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_flat[i*WIDTH +: WIDTH] = a;
        b_flat[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (gnt != 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok, output bit extra_gnt);
        ok        = 1'b0;
        extra_gnt = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (gnt != 0) extra_gnt = 1'b1;
            if (done != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        a_flat   = '0;
        b_flat   = '0;
        hold_low = 1'b0;
        repeat (3) tick();
        n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        n_checks++; if (done !== '0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (product !== '0) begin n_fail++; $display("FAIL reset_product got=%0d exp=0", product); end
        n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", mul_start); end
        n_checks++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_ops got=%0d/%0d exp=0/0", mul_a, mul_b); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok, extra;
        set_ops(0, 8'd13, 8'd11);
        req = 4'b0001;
        sb.push_back('{0, 16'd143});
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL single_start got=%b exp=1", mul_start); end
        n_checks++; if (mul_a !== 8'd13 || mul_b !== 8'd11) begin n_fail++; $display("FAIL single_ops got=%0d/%0d exp=13/11", mul_a, mul_b); end
        req = '0;
        wait_done(ok, extra);
        e = sb.pop_front();
        n_checks++; if (!ok || done !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL single_done got=%b exp=%b", done, 4'b0001 << e.idx); end
        n_checks++; if (product !== e.prod) begin n_fail++; $display("FAIL single_product got=%0d exp=%0d", product, e.prod); end
        tick();
        n_checks++; if (done !== '0 || product !== e.prod) begin n_fail++; $display("FAIL single_pulse done=%b product=%0d exp=0/%0d", done, product, e.prod); end
    endtask

    task automatic test_rotation();
        exp_t e;
        bit   ok, extra;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(i + 2), WIDTH'(i + 3));
        for (int j = 0; j < 8; j++) sb.push_back('{j % NREQ, 16'((j % NREQ + 2) * (j % NREQ + 3))});
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            wait_gnt(ok);
            e = sb.pop_front();
            n_checks++; if (!ok || gnt !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL rot_gnt%0d got=%b exp=%b", j, gnt, 4'b0001 << e.idx); end
            wait_done(ok, extra);
            if (j == 7) req = '0;
            n_checks++; if (!ok || extra || done !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL rot_done%0d got=%b exp=%b extra_gnt=%b", j, done, 4'b0001 << e.idx, extra); end
            n_checks++; if (product !== e.prod) begin n_fail++; $display("FAIL rot_product%0d got=%0d exp=%0d", j, product, e.prod); end
        end
    endtask

    task automatic test_boundary();
        exp_t e;
        bit   ok, extra;
        set_ops(1, 8'd255, 8'd255);
        sb.push_back('{1, 16'd65025});
        set_ops(2, 8'd0, 8'd200);
        sb.push_back('{2, 16'd0});
        for (int k = 0; k < 2; k++) begin
            e   = sb.pop_front();
            req = 4'b0001 << e.idx;
            wait_gnt(ok);
            n_checks++; if (!ok || gnt !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL bound_gnt%0d got=%b exp=%b", k, gnt, 4'b0001 << e.idx); end
            req = '0;
            wait_done(ok, extra);
            n_checks++; if (!ok || done !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL bound_done%0d got=%b exp=%b", k, done, 4'b0001 << e.idx); end
            n_checks++; if (product !== e.prod) begin n_fail++; $display("FAIL bound_product%0d got=%0d exp=%0d", k, product, e.prod); end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   ok, extra, saw_done;
        set_ops(0, 8'd9, 8'd9);
        req = 4'b0001;
        wait_gnt(ok);
        n_checks++; if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL abort_first_gnt got=%b exp=0001", gnt); end
        req = '0;
        repeat (2) tick();
        saw_done = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done != 0) saw_done = 1'b1;
        end
        reset = 1'b0;
        set_ops(2, 8'd7, 8'd9);
        sb.push_back('{2, 16'd63});
        req = 4'b0100;
        wait_gnt(ok);
        if (done != 0) saw_done = 1'b1;
        e = sb.pop_front();
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done got=1 exp=0"); end
        n_checks++; if (!ok || gnt !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL abort_gnt got=%b exp=%b", gnt, 4'b0001 << e.idx); end
        req = '0;
        wait_done(ok, extra);
        n_checks++; if (!ok || done !== (4'b0001 << e.idx) || product !== e.prod) begin n_fail++; $display("FAIL abort_result done=%b product=%0d exp=%b/%0d", done, product, 4'b0001 << e.idx, e.prod); end
    endtask

    task automatic test_ready_hold();
        exp_t e;
        bit   ok, extra, saw_gnt;
        hold_low = 1'b1;
        set_ops(1, 8'd5, 8'd6);
        sb.push_back('{1, 16'd30});
        req     = 4'b0010;
        saw_gnt = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (gnt != 0) saw_gnt = 1'b1;
        end
        n_checks++; if (saw_gnt) begin n_fail++; $display("FAIL hold_no_gnt got=1 exp=0"); end
        hold_low = 1'b0;
        tick();
        e = sb.pop_front();
        n_checks++; if (gnt !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL hold_gnt got=%b exp=%b", gnt, 4'b0001 << e.idx); end
        req = '0;
        wait_done(ok, extra);
        n_checks++; if (!ok || done !== (4'b0001 << e.idx) || product !== e.prod) begin n_fail++; $display("FAIL hold_result done=%b product=%0d exp=%b/%0d", done, product, 4'b0001 << e.idx, e.prod); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_boundary();
        test_reset_abort();
        test_ready_hold();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
